refill_responder: RTL
=====================

Name: refill_responder

Overview:
- Main-memory responder that services cache-miss refill and write requests from the instruction cache (IF stage) and data cache (MA stage).
- It is the far end of the Imiss/Dmiss protocol.
- It arbitrates between the two requesters, models fixed access latency, and returns a line as a burst of words.
- Single-word stores from the data side are also accepted.

Parameters:
- ADDR_W, 10, word-address bits of the internal memory array (DEPTH = 2**ADDR_W words of 32 bits).
- BURST_LOG2, 2, log2 of the line length in words (BURST_LEN = 2**BURST_LOG2).
- LATENCY, 4, wait cycles between request acceptance and the first returned word; legal range 1..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- i_ireq  in  1  I-side refill request, level; held until o_idone.
- i_iaddr  in  32  I-side byte address.
- o_ivalid  out  1  I-side burst word valid.
- o_idata  out  32  I-side burst word.
- o_iword  out  BURST_LOG2  index of the current I-side word within the line.
- o_idone  out  1  one-cycle pulse: I-side transaction complete.
- i_dreq  in  1  D-side request, level; held until o_ddone.
- i_dwe  in  1  D-side request type: 1 = single-word write, 0 = line refill.
- i_daddr  in  32  D-side byte address.
- i_dwdata  in  32  D-side write data.
- o_dvalid  out  1  D-side burst word valid.
- o_ddata  out  32  D-side burst word.
- o_dword  out  BURST_LOG2  index of the current D-side word within the line.
- o_ddone  out  1  one-cycle pulse: D-side transaction complete.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-low.
- Registered outputs: all outputs are registered.
- Reset values:
  - All outputs 0; state IDLE; lastsrv = I (so D wins the first tie); counters 0.
  - The memory array is not reset.
- Reset mid-transaction aborts it: no valid or done pulses are issued, and the requester must re-request.
- States: IDLE -> WAIT -> (BURST | WRITE) -> DONE -> IDLE.
- IDLE:
  - Samples i_ireq and i_dreq each cycle.
  - Only one requesting: that side is accepted.
  - Both requesting: the side not in lastsrv wins (round-robin).
  - On acceptance, latch: side, type (D only; I is always refill), word address (addr[ADDR_W+1:2]) and write data. Load the latency counter with LATENCY; go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, go to BURST for a refill or WRITE for a write. WAIT therefore lasts exactly LATENCY cycles.
- BURST:
  - BURST_LEN consecutive cycles, with the winning side's valid high in every one.
  - Words are returned in ascending order from line base = latched word address with its low BURST_LOG2 bits cleared. No critical-word-first.
  - Word index k = 0..BURST_LEN-1 is driven on o_xword; data = mem[base+k]. Address arithmetic is modulo 2**ADDR_W; upper address bits above ADDR_W+1 are ignored.
  - After the last word, go to DONE.
- WRITE: one cycle; mem[latched word addr] <= latched data. No valid pulse; go to DONE.
- DONE: one cycle; the served side's done = 1; update lastsrv; go to IDLE.
- Per-side signals: the non-served side's valid/done/word/data outputs stay 0 throughout.
- Timing, counted from the accept edge E0:
  - Refill: first valid in cycle LATENCY+1, last valid in cycle LATENCY+BURST_LEN, done in cycle LATENCY+BURST_LEN+1.
  - Write: done in cycle LATENCY+2.
- Request-line rules:
  - Deassertion of a request line after acceptance is ignored; the transaction completes and done is still pulsed.
  - A request still high in the IDLE cycle after DONE is treated as a new request. Requesters must drop req on the edge following their done.
- Read-after-write: a refill accepted after a write's DONE returns the written data.
- Idle data: o_idata and o_ddata are 0 when the corresponding valid is 0.

Test Plan:
- Reset then i_ireq=1, i_iaddr=0x0000_0014, LATENCY=4, mem preloaded mem[n]=n:
  - o_ivalid high for cycles 5..8 after acceptance, o_iword 0..3, o_idata 4,5,6,7.
  - o_idone pulses in cycle 9; o_busy high for cycles 1..9.
- i_dreq=1, i_dwe=1, i_daddr=0x8, i_dwdata=0xDEADBEEF:
  - o_ddone pulses in cycle 6, with no o_dvalid.
  - A following D refill at 0x0 returns words 0,1,0xDEADBEEF,3.
- i_ireq and i_dreq asserted in the same cycle after reset:
  - D is served first and I is accepted next.
  - On repeated simultaneous requests, service alternates I, D, I.
- Assert Rst low during BURST at word 2:
  - All outputs go 0 immediately and state is IDLE; no o_idone.
  - After release, a new request is served normally.
- i_ireq dropped to 0 during WAIT: the burst and o_idone still occur with unchanged timing.
- Address 0x0000_0FFC with ADDR_W=10: base word 0x3FC; burst returns mem[0x3FC..0x3FF]; upper address bits are ignored.

Source files
------------

// File: rtl/refill_responder.sv
// Main-memory responder for I-cache and D-cache miss traffic: round-robin arbitration,
// fixed access latency, line refills returned as ascending word bursts, single-word stores.
module refill_responder #(
    parameter int ADDR_W     = 10,
    parameter int BURST_LOG2 = 2,
    parameter int LATENCY    = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  i_ireq,
    input  logic [31:0]           i_iaddr,
    output logic                  o_ivalid,
    output logic [31:0]           o_idata,
    output logic [BURST_LOG2-1:0] o_iword,
    output logic                  o_idone,
    input  logic                  i_dreq,
    input  logic                  i_dwe,
    input  logic [31:0]           i_daddr,
    input  logic [31:0]           i_dwdata,
    output logic                  o_dvalid,
    output logic [31:0]           o_ddata,
    output logic [BURST_LOG2-1:0] o_dword,
    output logic                  o_ddone,
    output logic                  o_busy
);
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [7:0] LAT_LOAD = 8'(LATENCY);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [7:0]            r_cnt;
    logic [BURST_LOG2-1:0] r_beat;
    logic                  r_side;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_waddr;
    logic [31:0]           r_wdata;
    logic                  r_lastD;
    logic [31:0]           r_mem [DEPTH];

    logic                  r_ivalid;
    logic [31:0]           r_idata;
    logic [BURST_LOG2-1:0] r_iword;
    logic                  r_idone;
    logic                  r_dvalid;
    logic [31:0]           r_ddata;
    logic [BURST_LOG2-1:0] r_dword;
    logic                  r_ddone;
    logic                  r_busy;

    logic                  w_grantD;
    logic                  w_accept;
    logic [ADDR_W-1:0]     w_reqAddr;
    logic [BURST_LOG2-1:0] w_nextBeat;
    logic [BURST_LOG2-1:0] w_rdIdx;
    logic [31:0]           w_rdData;
    logic                  w_unused;

    // D takes a tie unless it was the last side served; r_side/r_lastD use 1 = D.
    assign w_grantD   = i_dreq & (~i_ireq | ~r_lastD);
    assign w_accept   = i_ireq | i_dreq;
    assign w_reqAddr  = w_grantD ? i_daddr[ADDR_W+1:2] : i_iaddr[ADDR_W+1:2];
    assign w_nextBeat = r_beat + 1'b1;
    assign w_rdIdx    = (r_state == S_BURST) ? w_nextBeat : '0;
    assign w_rdData   = r_mem[{r_waddr[ADDR_W-1:BURST_LOG2], w_rdIdx}];
    assign w_unused   = &{1'b0, i_iaddr[31:ADDR_W+2], i_iaddr[1:0],
                          i_daddr[31:ADDR_W+2], i_daddr[1:0]};

    always_ff @(posedge Clk) begin
        if (r_state == S_WRITE) begin
            r_mem[r_waddr] <= r_wdata;
        end
    end

    // Outputs are loaded on the same edge that enters each state, so they line up with it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_beat   <= '0;
            r_side   <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_lastD  <= 1'b0;
            r_ivalid <= 1'b0;
            r_idata  <= '0;
            r_iword  <= '0;
            r_idone  <= 1'b0;
            r_dvalid <= 1'b0;
            r_ddata  <= '0;
            r_dword  <= '0;
            r_ddone  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_WAIT;
                        r_cnt   <= LAT_LOAD;
                        r_side  <= w_grantD;
                        r_we    <= w_grantD & i_dwe;
                        r_waddr <= w_reqAddr;
                        r_wdata <= i_dwdata;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 8'd1) begin
                        r_beat <= '0;
                        if (r_we) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state  <= S_BURST;
                            r_ivalid <= ~r_side;
                            r_dvalid <= r_side;
                            r_iword  <= r_side ? '0 : w_rdIdx;
                            r_dword  <= r_side ? w_rdIdx : '0;
                            r_idata  <= r_side ? '0 : w_rdData;
                            r_ddata  <= r_side ? w_rdData : '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_BURST: begin
                    if (&r_beat) begin
                        r_state  <= S_DONE;
                        r_ivalid <= 1'b0;
                        r_dvalid <= 1'b0;
                        r_iword  <= '0;
                        r_dword  <= '0;
                        r_idata  <= '0;
                        r_ddata  <= '0;
                        r_idone  <= ~r_side;
                        r_ddone  <= r_side;
                    end else begin
                        r_beat  <= w_nextBeat;
                        r_iword <= r_side ? '0 : w_rdIdx;
                        r_dword <= r_side ? w_rdIdx : '0;
                        r_idata <= r_side ? '0 : w_rdData;
                        r_ddata <= r_side ? w_rdData : '0;
                    end
                end
                S_WRITE: begin
                    r_state <= S_DONE;
                    r_idone <= ~r_side;
                    r_ddone <= r_side;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_idone <= 1'b0;
                    r_ddone <= 1'b0;
                    r_busy  <= 1'b0;
                    r_lastD <= r_side;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ivalid = r_ivalid;
    assign o_idata  = r_idata;
    assign o_iword  = r_iword;
    assign o_idone  = r_idone;
    assign o_dvalid = r_dvalid;
    assign o_ddata  = r_ddata;
    assign o_dword  = r_dword;
    assign o_ddone  = r_ddone;
    assign o_busy   = r_busy;

endmodule
